cpu_run_monitor: RTL

Parametrised run-control and register-trace unit for the 5-stage MIPS pipeline. It snoops the write-back port of the register file into a shadow copy and evaluates up to NUM_WATCH register/value watchpoints plus a cycle-limit timeout. It raises a sticky halt and streams a full register dump over a ready/valid port. It replaces ad-hoc stop conditions and periodic register printing with a synthesizable block usable in simulation and on FPGA.

---
 rtl/cpu_mon_pkg.sv | 14 +
 rtl/cpu_mon_watch.sv | 13 +
 rtl/cpu_run_monitor.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cpu_mon_pkg.sv
// Shared types and constants for the CPU run monitor.
package cpu_mon_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DUMP   = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   localparam int unsigned CAUSE_WATCH   = 0;
   localparam int unsigned CAUSE_TIMEOUT = 1;
   localparam int unsigned CAUSE_W       = 2;

endpackage

// File: rtl/cpu_mon_watch.sv
// One watchpoint channel: compares a shadow register read against a target value.
module cpu_mon_watch #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              i_en,
   input  logic [DATA_W-1:0] i_val,
   input  logic [DATA_W-1:0] i_rd_data,
   output logic              o_match_c
);

   assign o_match_c = i_en && (i_rd_data == i_val);

endmodule

// File: rtl/cpu_run_monitor.sv
// Run-control monitor: shadow register file, watch/timeout halt, register dump stream.
module cpu_run_monitor
   import cpu_mon_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned NUM_WATCH = 2,
   parameter int unsigned CYC_W     = 16
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_wb_en,
   input  logic [ADDR_W-1:0]           i_wb_addr,
   input  logic [DATA_W-1:0]           i_wb_data,
   input  logic [NUM_WATCH-1:0]        i_watch_en,
   input  logic [NUM_WATCH*ADDR_W-1:0] i_watch_addr,
   input  logic [NUM_WATCH*DATA_W-1:0] i_watch_val,
   input  logic [CYC_W-1:0]            i_cycle_limit,
   input  logic                        i_dump_req,
   output logic                        o_halt,
   output logic [CAUSE_W-1:0]          o_halt_cause,
   output logic [CYC_W-1:0]            o_cycle_count,
   output logic                        o_dump_valid,
   input  logic                        i_dump_ready,
   output logic [ADDR_W-1:0]           o_dump_idx,
   output logic [DATA_W-1:0]           o_dump_data,
   output logic                        o_dump_last
);

   localparam int unsigned NUM_REGS = 1 << ADDR_W;

   logic [DATA_W-1:0]  r_shadow [NUM_REGS];
   state_e             r_state, w_state_nx;
   logic               r_ret_halt, w_ret_halt_nx;
   logic               r_redump, w_redump_nx;
   logic               r_halt, w_halt_nx;
   logic [CAUSE_W-1:0] r_cause, w_cause_nx;
   logic [CYC_W-1:0]   r_cnt, w_cnt_nx;
   logic               r_valid, w_valid_nx;
   logic [ADDR_W-1:0]  r_idx, w_idx_nx;
   logic               r_last, w_last_nx;

   logic [NUM_WATCH-1:0] w_match;
   logic                 w_watch_hit;
   logic                 w_tmo_hit;
   logic                 w_halt_cond;
   logic                 w_beat;

   // Shadow register file; index 0 stays hard zero.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) r_shadow[i] <= '0;
      end else if (i_wb_en && (i_wb_addr != '0)) begin
         r_shadow[i_wb_addr] <= i_wb_data;
      end
   end

   for (genvar g = 0; g < NUM_WATCH; g++) begin : g_watch
      cpu_mon_watch #(.DATA_W(DATA_W)) u_watch (
         .i_en      (i_watch_en[g]),
         .i_val     (i_watch_val[g*DATA_W +: DATA_W]),
         .i_rd_data (r_shadow[i_watch_addr[g*ADDR_W +: ADDR_W]]),
         .o_match_c (w_match[g])
      );
   end

   assign w_watch_hit = (|i_watch_en) && (&(w_match | ~i_watch_en));
   assign w_tmo_hit   = (i_cycle_limit != '0) && (r_cnt == i_cycle_limit);
   assign w_halt_cond = !r_halt && (w_watch_hit || w_tmo_hit);
   assign w_beat      = r_valid && i_dump_ready;

   // Next-state and output logic.
   always_comb begin
      w_state_nx    = r_state;
      w_ret_halt_nx = r_ret_halt;
      w_redump_nx   = r_redump;
      w_halt_nx     = r_halt;
      w_cause_nx    = r_cause;
      w_cnt_nx      = r_cnt;
      w_valid_nx    = r_valid;
      w_idx_nx      = r_idx;

      if (w_halt_cond) begin
         w_halt_nx                = 1'b1;
         w_cause_nx[CAUSE_WATCH]   = w_watch_hit;
         w_cause_nx[CAUSE_TIMEOUT] = w_tmo_hit;
      end else if (!r_halt && (r_cnt != '1)) begin
         w_cnt_nx = r_cnt + CYC_W'(1);
      end

      case (r_state)
         ST_RUN: begin
            if (w_halt_cond || r_redump) begin
               w_state_nx    = ST_DUMP;
               w_ret_halt_nx = 1'b1;
               w_redump_nx   = 1'b0;
               w_valid_nx    = 1'b1;
               w_idx_nx      = '0;
            end else if (i_dump_req) begin
               w_state_nx    = ST_DUMP;
               w_ret_halt_nx = 1'b0;
               w_valid_nx    = 1'b1;
               w_idx_nx      = '0;
            end
         end
         ST_DUMP: begin
            // A halt during a manual dump queues a second, halting dump.
            if (w_halt_cond) w_redump_nx = 1'b1;
            if (w_beat) begin
               if (r_idx == ADDR_W'(NUM_REGS - 1)) begin
                  w_valid_nx = 1'b0;
                  w_idx_nx   = '0;
                  w_state_nx = r_ret_halt ? ST_HALTED : ST_RUN;
               end else begin
                  w_idx_nx = r_idx + ADDR_W'(1);
               end
            end
         end
         ST_HALTED: begin
            if (i_dump_req) begin
               w_state_nx    = ST_DUMP;
               w_ret_halt_nx = 1'b1;
               w_valid_nx    = 1'b1;
               w_idx_nx      = '0;
            end
         end
         default: w_state_nx = ST_RUN;
      endcase

      w_last_nx = w_valid_nx && (w_idx_nx == ADDR_W'(NUM_REGS - 1));
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= ST_RUN;
         r_ret_halt <= 1'b0;
         r_redump   <= 1'b0;
         r_halt     <= 1'b0;
         r_cause    <= '0;
         r_cnt      <= '0;
         r_valid    <= 1'b0;
         r_idx      <= '0;
         r_last     <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_ret_halt <= w_ret_halt_nx;
         r_redump   <= w_redump_nx;
         r_halt     <= w_halt_nx;
         r_cause    <= w_cause_nx;
         r_cnt      <= w_cnt_nx;
         r_valid    <= w_valid_nx;
         r_idx      <= w_idx_nx;
         r_last     <= w_last_nx;
      end
   end

   assign o_halt        = r_halt;
   assign o_halt_cause  = r_cause;
   assign o_cycle_count = r_cnt;
   assign o_dump_valid  = r_valid;
   assign o_dump_idx    = r_idx;
   assign o_dump_last   = r_last;
   assign o_dump_data   = r_shadow[r_idx];

endmodule
